// File: rtl/conv_stream_feeder_pkg.sv
// Shared types and constants for the convolution-engine stream feeder.
// Holds the run-state encoding, LFSR constants and default geometry.
package conv_tb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned LFSR_W = 16;
  // Taps for x^16+x^14+x^13+x^11+1 in a left-shifting Fibonacci register
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  localparam int unsigned DEF_N = 112;
  localparam int unsigned DEF_M = 49;
  localparam int unsigned DEF_W = 10;

endpackage

// File: rtl/conv_stream_feeder_if.sv
// x/f valid-ready stream bundle between the feeder (master) and the
// convolution engine (slave).
interface conv_stream_feeder_if #(
  parameter int unsigned W = 10
);
  logic signed [W-1:0] x_data;
  logic                x_valid;
  logic                x_ready;
  logic signed [W-1:0] f_data;
  logic                f_valid;
  logic                f_ready;

  modport master (
    output x_data, x_valid, f_data, f_valid,
    input  x_ready, f_ready
  );

  modport slave (
    input  x_data, x_valid, f_data, f_valid,
    output x_ready, f_ready
  );
endinterface

// File: rtl/conv_stream_feeder_stream_out_reg.sv
// One feeder channel: vector memory, element index and the registered
// valid/data output stage of a valid-ready source.
module stream_out_reg #(
  parameter int unsigned COUNT = 112,
  parameter int unsigned W     = 10,
  parameter int unsigned AW    = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_clear,
  input  logic                i_run,
  input  logic                i_gate,
  input  logic                i_we,
  input  logic [AW-1:0]       i_waddr,
  input  logic signed [W-1:0] i_wdata,
  input  logic                i_ready,
  output logic signed [W-1:0] o_data,
  output logic                o_valid,
  output logic                o_fin
);

  localparam int unsigned IW = $clog2(COUNT + 1);
  localparam int unsigned MW = (COUNT > 1) ? $clog2(COUNT) : 1;

  logic signed [W-1:0] r_mem [COUNT];
  logic signed [W-1:0] r_data;
  logic                r_valid;
  logic [IW-1:0]       r_idx;
  logic [MW-1:0]       w_waddr;
  logic [MW-1:0]       w_raddr;
  logic                w_load;

  assign w_waddr = MW'(i_waddr);
  assign w_raddr = MW'(r_idx);

  always_ff @(posedge clk) begin
    if (i_we && (32'(i_waddr) < COUNT)) begin
      r_mem[w_waddr] <= i_wdata;
    end
  end

  assign w_load = i_run && (!r_valid || i_ready) && (r_idx < IW'(COUNT)) && i_gate;

  // Data is left untouched on a bare acceptance; only valid drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_idx   <= '0;
    end else begin
      if (i_clear) begin
        r_idx <= '0;
      end
      if (w_load) begin
        r_data  <= r_mem[w_raddr];
        r_valid <= 1'b1;
        r_idx   <= r_idx + 1'b1;
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_fin   = (r_idx == IW'(COUNT)) && !r_valid;

endmodule

// File: rtl/conv_stream_feeder.sv
// Synthesizable x/f stimulus source for a conv_<N>_<M> engine, with
// LFSR-driven channel gaps to exercise backpressure and bubbles.
module conv_stream_feeder
  import conv_tb_pkg::*;
#(
  parameter int unsigned       N    = DEF_N,
  parameter int unsigned       M    = DEF_M,
  parameter int unsigned       W    = DEF_W,
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_we,
  input  logic                 cfg_sel,
  input  logic [$clog2(N)-1:0] cfg_addr,
  input  logic signed [W-1:0]  cfg_wdata,
  input  logic                 start,
  input  logic                 throttle_en,
  conv_stream_feeder_if.master strm,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned AW = $clog2(N);

  state_t              r_state;
  state_t              w_next;
  logic [LFSR_W-1:0]   r_lfsr;
  logic                w_idle;
  logic                w_run;
  logic                w_x_gate;
  logic                w_f_gate;
  logic                w_x_we;
  logic                w_f_we;
  logic                w_x_fin;
  logic                w_f_fin;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= {r_lfsr[LFSR_W-2:0], ^(r_lfsr & LFSR_TAPS)};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_x_fin && w_f_fin) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign w_idle   = (r_state == IDLE);
  assign w_run    = (r_state == RUN);
  assign w_x_gate = throttle_en ? r_lfsr[0] : 1'b1;
  assign w_f_gate = throttle_en ? r_lfsr[1] : 1'b1;
  assign w_x_we   = cfg_we && w_idle && !cfg_sel;
  assign w_f_we   = cfg_we && w_idle && cfg_sel;

  assign busy = !w_idle;
  assign done = (r_state == DONE);

  stream_out_reg #(
    .COUNT (N),
    .W     (W),
    .AW    (AW)
  ) u_x (
    .clk     (clk),
    .rst     (reset),
    .i_clear (w_idle),
    .i_run   (w_run),
    .i_gate  (w_x_gate),
    .i_we    (w_x_we),
    .i_waddr (cfg_addr),
    .i_wdata (cfg_wdata),
    .i_ready (strm.x_ready),
    .o_data  (strm.x_data),
    .o_valid (strm.x_valid),
    .o_fin   (w_x_fin)
  );

  stream_out_reg #(
    .COUNT (M),
    .W     (W),
    .AW    (AW)
  ) u_f (
    .clk     (clk),
    .rst     (reset),
    .i_clear (w_idle),
    .i_run   (w_run),
    .i_gate  (w_f_gate),
    .i_we    (w_f_we),
    .i_waddr (cfg_addr),
    .i_wdata (cfg_wdata),
    .i_ready (strm.f_ready),
    .o_data  (strm.f_data),
    .o_valid (strm.f_valid),
    .o_fin   (w_f_fin)
  );

endmodule

// File: tb/tb_conv_stream_feeder.sv
// Scoreboard bench for conv_stream_feeder: stimulus pushes expected
// element sequences, a negedge monitor pops them on every handshake.
module tb_conv_stream_feeder;

  localparam int unsigned N = 112;
  localparam int unsigned M = 49;
  localparam int unsigned W = 10;

  logic                 clk;
  logic                 reset;
  logic                 cfg_we;
  logic                 cfg_sel;
  logic [$clog2(N)-1:0] cfg_addr;
  logic signed [W-1:0]  cfg_wdata;
  logic                 start;
  logic                 throttle_en;
  logic                 busy;
  logic                 done;

  conv_stream_feeder_if #(.W(W)) strm ();

  conv_stream_feeder #(
    .N    (N),
    .M    (M),
    .W    (W),
    .SEED (16'hACE1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_we      (cfg_we),
    .cfg_sel     (cfg_sel),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
    .start       (start),
    .throttle_en (throttle_en),
    .strm        (strm),
    .busy        (busy),
    .done        (done)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int xm [N];
  int fm [M];
  int xq [$];
  int fq [$];
  int x_hs     = 0;
  int f_hs     = 0;
  int done_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input bit sel, input int addr, input int val);
    cfg_we    = 1'b1;
    cfg_sel   = sel;
    cfg_addr  = 7'(addr);
    cfg_wdata = 10'(val);
    tick();
    cfg_we    = 1'b0;
  endtask

  // Optionally writes x[addr]=val in the same IDLE cycle as start.
  task automatic run_start(input bit with_wr, input int addr, input int val);
    if (with_wr) begin
      xm[addr]  = val;
      cfg_we    = 1'b1;
      cfg_sel   = 1'b0;
      cfg_addr  = 7'(addr);
      cfg_wdata = 10'(val);
    end
    for (int i = 0; i < int'(N); i++) xq.push_back(xm[i]);
    for (int i = 0; i < int'(M); i++) fq.push_back(fm[i]);
    start = 1'b1;
    tick();
    start  = 1'b0;
    cfg_we = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (!done && n < bound) begin
      tick();
      n++;
    end
    chk("done_reached", int'(done), 1);
  endtask

  task automatic chk_drained(input string tag);
    chk({tag, "_xq_empty"}, xq.size(), 0);
    chk({tag, "_fq_empty"}, fq.size(), 0);
  endtask

  // Monitor: handshake ordering, hold-until-accepted, single-cycle done.
  initial begin
    bit               px_hold = 0;
    bit               pf_hold = 0;
    bit               p_done  = 0;
    logic signed [W-1:0] px_d, pf_d;
    px_d = '0;
    pf_d = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        px_hold = 0;
        pf_hold = 0;
        p_done  = 0;
        continue;
      end
      if (px_hold) begin
        chk("x_hold_valid", int'(strm.x_valid), 1);
        chk("x_hold_data", int'(strm.x_data), int'(px_d));
      end
      if (pf_hold) begin
        chk("f_hold_valid", int'(strm.f_valid), 1);
        chk("f_hold_data", int'(strm.f_data), int'(pf_d));
      end
      if (strm.x_valid && strm.x_ready) begin
        if (xq.size() == 0) chk("x_unexpected", int'(strm.x_data), 9999);
        else chk("x_data", int'(strm.x_data), xq.pop_front());
        x_hs++;
      end
      if (strm.f_valid && strm.f_ready) begin
        if (fq.size() == 0) chk("f_unexpected", int'(strm.f_data), 9999);
        else chk("f_data", int'(strm.f_data), fq.pop_front());
        f_hs++;
      end
      if (done) begin
        chk("done_one_cycle", int'(p_done), 0);
        done_cnt++;
      end
      px_hold = strm.x_valid && !strm.x_ready;
      pf_hold = strm.f_valid && !strm.f_ready;
      px_d    = strm.x_data;
      pf_d    = strm.f_data;
      p_done  = done;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, xfirst, xlast, xcnt, ffirst, flast, fcnt, done_at;
    int stall, f_before, base;
    bit stalled;

    reset = 1'b1; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    start = 1'b0; throttle_en = 1'b0;
    strm.x_ready = 1'b1;
    strm.f_ready = 1'b1;
    repeat (3) tick();
    chk("rst_x_valid", int'(strm.x_valid), 0);
    chk("rst_f_valid", int'(strm.f_valid), 0);
    chk("rst_x_data", int'(strm.x_data), 0);
    chk("rst_f_data", int'(strm.f_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < int'(N); i++) begin xm[i] = i - 128; cfg_write(1'b0, i, xm[i]); end
    for (int i = 0; i < int'(M); i++) begin fm[i] = i - 64;  cfg_write(1'b1, i, fm[i]); end
    // f address 70 is out of range; a truncating decoder would hit f[6]
    cfg_write(1'b1, 70, 99);

    // Run 1: full rate, plus an ignored write and start mid-run
    run_start(1'b0, 0, 0);
    chk("r1_valid_lat0", int'(strm.x_valid), 0);
    chk("r1_busy", int'(busy), 1);
    cyc = 0; xfirst = -1; xlast = -1; xcnt = 0; ffirst = -1; flast = -1; fcnt = 0; done_at = -1;
    while (cyc < 400) begin
      tick();
      cyc++;
      if (cyc == 10) begin
        chk("r1_busy_mid", int'(busy), 1);
        cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = '0; cfg_wdata = 10'sd7; start = 1'b1;
      end else if (cyc == 11) begin
        cfg_we = 1'b0; start = 1'b0;
      end
      if (strm.x_valid) begin if (xfirst < 0) xfirst = cyc; xlast = cyc; xcnt++; end
      if (strm.f_valid) begin if (ffirst < 0) ffirst = cyc; flast = cyc; fcnt++; end
      if (done) begin done_at = cyc; break; end
    end
    chk("r1_x_first", xfirst, 1);
    chk("r1_x_count", xcnt, int'(N));
    chk("r1_x_span", xlast - xfirst + 1, int'(N));
    chk("r1_f_count", fcnt, int'(M));
    chk("r1_f_span", flast - ffirst + 1, int'(M));
    chk("r1_done_lat", done_at - xlast, 2);
    tick();
    chk("r1_idle_busy", int'(busy), 0);
    chk("r1_idle_done", int'(done), 0);
    chk_drained("r1");

    // Run 2: x stalled 20 cycles at element 5 while f keeps flowing
    run_start(1'b0, 0, 0);
    stall = 0; stalled = 0; f_before = 0; cyc = 0;
    while (!done && cyc < 400) begin
      tick();
      cyc++;
      if (!stalled && strm.x_valid && int'(strm.x_data) == -123) begin
        stalled = 1; stall = 20; f_before = f_hs;
        strm.x_ready = 1'b0;
      end else if (stall > 0) begin
        stall--;
        if (stall == 0) begin
          chk("r2_stall_data", int'(strm.x_data), -123);
          chk("r2_stall_valid", int'(strm.x_valid), 1);
          chk("r2_f_progress", f_hs - f_before, 20);
          strm.x_ready = 1'b1;
        end
      end
    end
    chk("r2_stall_reached", int'(stalled), 1);
    chk("r2_done", int'(done), 1);
    tick();
    chk_drained("r2");

    // Run 3: LFSR throttling with random readies
    throttle_en = 1'b1;
    base = done_cnt;
    run_start(1'b0, 0, 0);
    cyc = 0;
    while (!done && cyc < 5000) begin
      strm.x_ready = 1'($urandom_range(0, 1));
      strm.f_ready = 1'($urandom_range(0, 1));
      tick();
      cyc++;
    end
    chk("r3_done", int'(done), 1);
    throttle_en = 1'b0; strm.x_ready = 1'b1; strm.f_ready = 1'b1;
    repeat (3) tick();
    chk("r3_done_count", done_cnt - base, 1);
    chk_drained("r3");

    // Run 4: reset after 50 x handshakes
    base = x_hs;
    run_start(1'b0, 0, 0);
    cyc = 0;
    while (x_hs - base < 50 && cyc < 300) begin tick(); cyc++; end
    chk("r4_hs50", x_hs - base, 50);
    reset = 1'b1;
    #1;
    chk("r4_rst_x_valid", int'(strm.x_valid), 0);
    chk("r4_rst_f_valid", int'(strm.f_valid), 0);
    chk("r4_rst_x_data", int'(strm.x_data), 0);
    chk("r4_rst_f_data", int'(strm.f_data), 0);
    chk("r4_rst_busy", int'(busy), 0);
    chk("r4_rst_done", int'(done), 0);
    xq.delete();
    fq.delete();
    tick();
    reset = 1'b0;
    tick();

    // Runs 5/6: write+start together, then back-to-back restart
    base = done_cnt;
    run_start(1'b1, 3, 33);
    wait_done(400);
    tick();
    chk("r5_idle_busy", int'(busy), 0);
    chk_drained("r5");
    run_start(1'b0, 0, 0);
    chk("r6_busy", int'(busy), 1);
    wait_done(400);
    repeat (2) tick();
    chk_drained("r6");
    chk("r56_done_count", done_cnt - base, 2);
    chk("total_done_count", done_cnt, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_stream_feeder.md
# conv_stream_feeder

Synthesizable stream source that drives the x and f input channels of a `conv_<N>_<M>` convolution engine with one test vector pair held in internal register memories. It is the transmitter end of the engine's x/f valid-ready interfaces and replaces the behavioural stimulus process in on-chip self-test and FPGA bring-up. Channel gaps come from an internal LFSR, so backpressure and bubble handling are exercised in hardware.

## Interface
- `N`, 112: number of x elements per run.
- `M`, 49: number of f elements per run.
- `W`, 10: data width of x and f (signed).
- `SEED`, 16'hACE1: LFSR reset value; must be nonzero.
- `clk` input 1: clock, all logic on rising edge.
- `reset` input 1: asynchronous, active-high; clears all state except the memories.
- `cfg_we` input 1: memory write strobe.
- `cfg_sel` input 1: target memory; 0 = x memory, 1 = f memory.
- `cfg_addr` input $clog2(N): write address. Out-of-range addresses (x: ≥N; f: ≥M) are ignored.
- `cfg_wdata` input W: write data.
- `start` input 1: begin a run; acted on only in IDLE.
- `throttle_en` input 1: 1 = insert LFSR-driven gaps; 0 = full rate.
- `x_data` output W signed: x element. Reset value 0.
- `x_valid` output 1: x element valid. Reset value 0.
- `x_ready` input 1: engine accepts x.
- `f_data` output W signed: f element. Reset value 0.
- `f_valid` output 1: f element valid. Reset value 0.
- `f_ready` input 1: engine accepts f.
- `busy` output 1: high in RUN and DONE. Reset value 0.
- `done` output 1: one-cycle pulse at end of run. Reset value 0.

## Operation
- States:
  - IDLE: `start` moves to RUN. The counts `x_idx` and `f_idx` are cleared to 0.
  - RUN: both channels stream independently. When all elements have been accepted, go to DONE.
  - DONE: `done`=1 for exactly one cycle, then return to IDLE.
- Memory writes: committed only in IDLE. `cfg_we` in RUN or DONE is dropped.
  - A write and `start` in the same IDLE cycle both take effect. The written value is used by the run.
- Each channel has one output register (data + valid), with the same rule for x and f:
  - Load condition: in RUN, load when (register empty, or valid && ready this cycle) && idx < count && gate.
  - On load: data ← mem[idx], valid ← 1, idx ← idx+1.
  - Accept without a load: valid ← 0. Data holds its last value.
- Once valid is asserted, valid and data stay constant until the element is accepted. Valid never drops without a handshake.
- Gates: x gate = `lfsr[0]` and f gate = `lfsr[1]` when `throttle_en`=1; both gates = 1 otherwise.
- LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1. Advances every cycle in every state. Resets to `SEED`.
- End of run: when x_idx==N, f_idx==M and both valids are 0 (after the final acceptances), RUN→DONE on the next edge.
- `start` during RUN or DONE is ignored. No queuing.
- Reset mid-run: outputs return to reset values immediately. The state returns to IDLE. Memories are unchanged, so a following `start` replays from element 0.

## Timing
- `start` sampled at edge k → RUN after edge k. First load at edge k+1, so `x_valid`/`f_valid` are high after edge k+1.
- Throughput: with `throttle_en`=0 and ready held high, one element per cycle per channel with no bubbles.
  - x is valid for N consecutive cycles, f for M consecutive cycles.
- Last handshake at edge j → DONE after edge j+1 → `done` high for the cycle following j+1. IDLE after edge j+2.
- `start` in the first IDLE cycle after DONE is accepted. Back-to-back runs are legal.
- `x_data`/`f_data` and the valids come directly from registers. There is no combinational path from ready to valid or data.

## Structure
- Package `conv_tb_pkg`: state enum (IDLE, RUN, DONE), LFSR width/tap constant, default N/M/W.
- Sub-module `stream_out_reg`: the per-channel output register with memory index counter, instantiated twice (x, f) with its count parameter.
- Memories are plain register arrays, no reset. Reads are synchronous into the output register.

## Test plan
Common setup: load x[i]=i-128 (i=0..111) and f[i]=i-64 (i=0..48), then `start`.
- Full rate, ready=1, `throttle_en`=0 → `x_valid` high for 112 contiguous cycles starting 2 edges after `start`, data -128..-17. f carries -64..-16 over 49 cycles. A single `done` pulse 2 edges after the last x handshake.
- Hold `x_ready`=0 for 20 cycles at element 5 → `x_data`=-123 and `x_valid`=1 stable throughout. The f channel continues independently. x resumes at -122.
- `throttle_en`=1 with random readies → accepted sequences exactly match memory order. No valid deassertion without a handshake. Exactly one `done` pulse.
- `cfg_we` writing x[0]=7 during RUN, and `start` pulsed during RUN → both ignored. The next run still emits -128 first.
- Assert `reset` after 50 x handshakes → all outputs 0 next cycle. After a new `start`, the run replays from -128 / -64.
- `start` in the cycle right after IDLE re-entry → second run identical to the first. `done` pulses twice in total.
